// File: rtl/fe_timestamp_sequencer.sv
// rtl/fe_timestamp_sequencer.sv - trace front-end event to FIFO-entry sequencer with timestamps and drop counting
//
// Ports:
//   trace_clk, reset          clock and synchronous active-high reset
//   I_arm                     capture enable (level); rising edge restarts ts and clears drop stats
//   I_event, I_data_cmd       front-end event strobe and the command it logs
//   I_max_short_timestamp     largest ts that fits in a short (single) entry
//   I_fifo_full               downstream FIFO cannot take a write this cycle
//   O_fifo_wr/command/time    registered FIFO write strobe and entry contents
//   O_busy                    second half of a TIME+event pair is pending
//   O_dropped, O_drop_count   sticky drop flag and saturating drop counter

`ifndef FE_FIFO_CMD_DATA
`define FE_FIFO_CMD_DATA 2'b01
`endif
`ifndef FE_FIFO_CMD_STAT
`define FE_FIFO_CMD_STAT 2'b10
`endif
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

module fe_timestamp_sequencer #(
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pDROP_COUNT_WIDTH     = 16
) (
    input  logic                             trace_clk,
    input  logic                             reset,
    input  logic                             I_arm,
    input  logic                             I_event,
    input  logic [1:0]                       I_data_cmd,
    input  logic [15:0]                      I_max_short_timestamp,
    input  logic                             I_fifo_full,
    output logic                             O_fifo_wr,
    output logic [1:0]                       O_fifo_command,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
    output logic                             O_busy,
    output logic                             O_dropped,
    output logic [pDROP_COUNT_WIDTH-1:0]     O_drop_count
);

    localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] TS_ONES  = '1;
    localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] TS_ONE   = pTIMESTAMP_FULL_WIDTH'(1);
    localparam logic [pDROP_COUNT_WIDTH-1:0]     CNT_ONES = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LONG = 1'b1
    } state_t;

    state_t                             r_state, w_state_nxt;
    logic                               r_arm;
    logic [pTIMESTAMP_FULL_WIDTH-1:0]   r_ts, w_ts_nxt, w_ts_inc;
    logic [1:0]                         r_cmd_lat, w_cmd_lat_nxt;
    logic                               r_wr, w_wr_nxt;
    logic [1:0]                         r_cmd, w_cmd_nxt;
    logic [pTIMESTAMP_FULL_WIDTH-1:0]   r_time, w_time_nxt;
    logic                               r_dropped;
    logic [pDROP_COUNT_WIDTH-1:0]       r_drop_count;
    logic                               w_drop;
    logic                               w_clear;
    logic                               w_is_short;

    assign w_ts_inc   = (r_ts == TS_ONES) ? r_ts : r_ts + TS_ONE;
    assign w_is_short = 32'(r_ts) <= 32'(I_max_short_timestamp);

    always_comb begin
        w_state_nxt   = r_state;
        w_ts_nxt      = r_ts;
        w_cmd_lat_nxt = r_cmd_lat;
        w_wr_nxt      = 1'b0;
        w_cmd_nxt     = 2'b00;
        w_time_nxt    = '0;
        w_drop        = 1'b0;
        w_clear       = 1'b0;

        if (!I_arm) begin
            // Disarming abandons any half-written TIME+event pair.
            w_state_nxt = ST_IDLE;
        end else if (!r_arm) begin
            // First armed cycle only restarts the timebase; ts is not yet meaningful for an event.
            w_ts_nxt = '0;
            w_clear  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (I_event) begin
                        if (I_fifo_full) begin
                            w_drop   = 1'b1;
                            w_ts_nxt = w_ts_inc;
                        end else if (w_is_short) begin
                            w_wr_nxt   = 1'b1;
                            w_cmd_nxt  = I_data_cmd;
                            w_time_nxt = r_ts;
                            w_ts_nxt   = TS_ONE;
                        end else begin
                            w_wr_nxt      = 1'b1;
                            w_cmd_nxt     = `FE_FIFO_CMD_TIME;
                            w_time_nxt    = r_ts;
                            w_ts_nxt      = TS_ONE;
                            w_cmd_lat_nxt = I_data_cmd;
                            w_state_nxt   = ST_LONG;
                        end
                    end else if (!I_fifo_full && r_ts == TS_ONES) begin
                        // Saturated timebase: emit a marker so the reader can keep absolute time.
                        w_wr_nxt   = 1'b1;
                        w_cmd_nxt  = `FE_FIFO_CMD_TIME;
                        w_time_nxt = r_ts;
                        w_ts_nxt   = TS_ONE;
                    end else begin
                        w_ts_nxt = w_ts_inc;
                    end
                end
                ST_LONG: begin
                    // The front end keeps FIFO headroom for this entry, so fullness is not consulted.
                    w_wr_nxt    = 1'b1;
                    w_cmd_nxt   = r_cmd_lat;
                    w_time_nxt  = '0;
                    w_ts_nxt    = TS_ONE;
                    w_state_nxt = ST_IDLE;
                    w_drop      = I_event;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_arm        <= 1'b0;
            r_ts         <= '0;
            r_cmd_lat    <= 2'b00;
            r_wr         <= 1'b0;
            r_cmd        <= 2'b00;
            r_time       <= '0;
            r_dropped    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm     <= I_arm;
            r_ts      <= w_ts_nxt;
            r_cmd_lat <= w_cmd_lat_nxt;
            r_wr      <= w_wr_nxt;
            r_cmd     <= w_cmd_nxt;
            r_time    <= w_time_nxt;
            if (w_clear) begin
                r_dropped    <= 1'b0;
                r_drop_count <= '0;
            end else if (w_drop) begin
                r_dropped <= 1'b1;
                if (r_drop_count != CNT_ONES) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    assign O_fifo_wr      = r_wr;
    assign O_fifo_command = r_cmd;
    assign O_fifo_time    = r_time;
    assign O_busy         = (r_state == ST_LONG);
    assign O_dropped      = r_dropped;
    assign O_drop_count   = r_drop_count;

endmodule

// File: tb/tb_fe_timestamp_sequencer.sv
// tb/tb_fe_timestamp_sequencer.sv - self-checking bench for fe_timestamp_sequencer

`ifndef FE_FIFO_CMD_DATA
`define FE_FIFO_CMD_DATA 2'b01
`endif
`ifndef FE_FIFO_CMD_STAT
`define FE_FIFO_CMD_STAT 2'b10
`endif
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

module tb_fe_timestamp_sequencer;

    localparam int TS_MAX = 65535;

    logic        trace_clk = 1'b0;
    logic        reset = 1'b1;
    logic        I_arm = 1'b0;
    logic        I_event = 1'b0;
    logic [1:0]  I_data_cmd = 2'b00;
    logic [15:0] I_max_short_timestamp = 16'd255;
    logic        I_fifo_full = 1'b0;
    logic        O_fifo_wr;
    logic [1:0]  O_fifo_command;
    logic [15:0] O_fifo_time;
    logic        O_busy;
    logic        O_dropped;
    logic [15:0] O_drop_count;

    fe_timestamp_sequencer #(
        .pTIMESTAMP_FULL_WIDTH(16),
        .pDROP_COUNT_WIDTH(16)
    ) dut (
        .trace_clk            (trace_clk),
        .reset                (reset),
        .I_arm                (I_arm),
        .I_event              (I_event),
        .I_data_cmd           (I_data_cmd),
        .I_max_short_timestamp(I_max_short_timestamp),
        .I_fifo_full          (I_fifo_full),
        .O_fifo_wr            (O_fifo_wr),
        .O_fifo_command       (O_fifo_command),
        .O_fifo_time          (O_fifo_time),
        .O_busy               (O_busy),
        .O_dropped            (O_dropped),
        .O_drop_count         (O_drop_count)
    );

    always #5 trace_clk = ~trace_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed time since last entry, and whether an event entry is still owed.
    int m_ts = 0;
    bit m_prev_arm = 0;
    bit m_owed = 0;
    int m_owed_cmd = 0;
    bit m_wr = 0;
    int m_cmd = 0;
    int m_time = 0;
    bit m_dropped = 0;
    int m_drops = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_drop();
        m_dropped = 1;
        if (m_drops < 65535) m_drops++;
    endfunction

    function automatic void model_edge();
        m_wr = 0;
        m_cmd = 0;
        m_time = 0;
        if (reset) begin
            m_ts = 0; m_prev_arm = 0; m_owed = 0; m_dropped = 0; m_drops = 0;
            return;
        end
        if (!I_arm) begin
            m_owed = 0;
        end else if (!m_prev_arm) begin
            m_ts = 0; m_dropped = 0; m_drops = 0;
        end else if (m_owed) begin
            m_wr = 1; m_cmd = m_owed_cmd; m_time = 0; m_ts = 1; m_owed = 0;
            if (I_event) model_drop();
        end else if (I_event && I_fifo_full) begin
            model_drop();
            if (m_ts < TS_MAX) m_ts++;
        end else if (I_event) begin
            m_wr = 1; m_time = m_ts;
            if (m_ts <= int'(I_max_short_timestamp)) begin
                m_cmd = int'(I_data_cmd);
            end else begin
                m_cmd = `FE_FIFO_CMD_TIME;
                m_owed = 1;
                m_owed_cmd = int'(I_data_cmd);
            end
            m_ts = 1;
        end else if (!I_fifo_full && m_ts == TS_MAX) begin
            m_wr = 1; m_cmd = `FE_FIFO_CMD_TIME; m_time = TS_MAX; m_ts = 1;
        end else if (m_ts < TS_MAX) begin
            m_ts++;
        end
        m_prev_arm = I_arm;
    endfunction

    task automatic step();
        @(posedge trace_clk);
        #1;
        model_edge();
        check_eq("wr", O_fifo_wr, m_wr);
        if (m_wr) begin
            check_eq("cmd", O_fifo_command, m_cmd);
            check_eq("time", O_fifo_time, m_time);
        end
        check_eq("busy", O_busy, m_owed);
        check_eq("dropped", O_dropped, m_dropped);
        check_eq("drop_count", O_drop_count, m_drops);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_event(input logic [1:0] cmd);
        I_event = 1'b1;
        I_data_cmd = cmd;
        step();
        I_event = 1'b0;
    endtask

    task automatic rearm();
        I_arm = 1'b0;
        step();
        I_arm = 1'b1;
        step();
    endtask

    initial begin
        int seen;
        // Reset state
        reset = 1'b1;
        idle(2);
        check_eq("rst_wr", O_fifo_wr, 0);
        check_eq("rst_cnt", O_drop_count, 0);
        reset = 1'b0;
        idle(1);

        // Short entry at ts=10
        I_max_short_timestamp = 16'd255;
        I_arm = 1'b1;
        step();
        idle(10);
        pulse_event(`FE_FIFO_CMD_STAT);
        check_eq("t1_wr", O_fifo_wr, 1);
        check_eq("t1_cmd", O_fifo_command, `FE_FIFO_CMD_STAT);
        check_eq("t1_time", O_fifo_time, 10);

        // Events two cycles apart
        idle(1);
        pulse_event(`FE_FIFO_CMD_DATA);
        check_eq("t2_time", O_fifo_time, 2);
        check_eq("t2_busy", O_busy, 0);
        check_eq("t2_cnt", O_drop_count, 0);

        // Long path at ts=300 with a colliding event
        idle(299);
        pulse_event(`FE_FIFO_CMD_DATA);
        check_eq("t3_cmd0", O_fifo_command, `FE_FIFO_CMD_TIME);
        check_eq("t3_time0", O_fifo_time, 300);
        pulse_event(`FE_FIFO_CMD_STAT);
        check_eq("t3_wr1", O_fifo_wr, 1);
        check_eq("t3_cmd1", O_fifo_command, `FE_FIFO_CMD_DATA);
        check_eq("t3_time1", O_fifo_time, 0);
        check_eq("t3_cnt", O_drop_count, 1);
        check_eq("t3_dropped", O_dropped, 1);
        idle(3);

        // FIFO full drops, then re-arm clears
        rearm();
        I_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_event(`FE_FIFO_CMD_DATA);
            idle(2);
        end
        check_eq("t4_cnt", O_drop_count, 3);
        I_fifo_full = 1'b0;
        rearm();
        check_eq("t4_cnt_clr", O_drop_count, 0);
        check_eq("t4_drop_clr", O_dropped, 0);

        // Rollover marker after saturating idle
        seen = 0;
        for (int i = 0; i < 70000 && !seen; i++) begin
            step();
            if (O_fifo_wr) seen = 1;
        end
        check_eq("t5_seen", seen, 1);
        check_eq("t5_cmd", O_fifo_command, `FE_FIFO_CMD_TIME);
        check_eq("t5_time", O_fifo_time, 16'hFFFF);
        idle(4);
        pulse_event(`FE_FIFO_CMD_STAT);
        check_eq("t5_next", O_fifo_time, 5);

        // Reset right after a long-path event
        I_max_short_timestamp = 16'd0;
        idle(2);
        pulse_event(`FE_FIFO_CMD_DATA);
        check_eq("t6_cmd", O_fifo_command, `FE_FIFO_CMD_TIME);
        reset = 1'b1;
        step();
        check_eq("t6_wr", O_fifo_wr, 0);
        check_eq("t6_busy", O_busy, 0);
        check_eq("t6_time", O_fifo_time, 0);
        reset = 1'b0;
        idle(2);

        // Disarm right after a long-path event
        I_arm = 1'b1;
        idle(3);
        pulse_event(`FE_FIFO_CMD_STAT);
        I_arm = 1'b0;
        step();
        check_eq("t7_wr", O_fifo_wr, 0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) I_max_short_timestamp = 16'($urandom_range(0, 20));
            I_arm = ($urandom_range(0, 99) < 96);
            I_event = ($urandom_range(0, 99) < 30);
            I_fifo_full = ($urandom_range(0, 99) < 15);
            I_data_cmd = $urandom_range(0, 1) ? `FE_FIFO_CMD_DATA : `FE_FIFO_CMD_STAT;
            reset = ($urandom_range(0, 999) < 3);
            step();
        end
        reset = 1'b0;
        I_event = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
